// File: rtl/sdpram_if.sv
// Signal bundle for simple_dual_port_ram; parameters here size the attached RAM.
// Directions in the ram modport are as seen by the RAM.
interface sdpram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int OUT_REG    = 0
) ();
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [STRB_WIDTH-1:0] wena;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  renb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;

    modport ram (
        input  wena,
        input  addra,
        input  dina,
        input  renb,
        input  addrb,
        output doutb
    );
endinterface

// File: rtl/simple_dual_port_ram.sv
// Single-clock simple dual-port RAM: byte-strobed write port A, registered read port B,
// read-first on same-address collision, optional second output register.
module simple_dual_port_ram (
    input logic   clk,
    input logic   rst,
    sdpram_if.ram ifp
);
    localparam int DATA_WIDTH = ifp.DATA_WIDTH;
    localparam int MEM_DEPTH  = ifp.MEM_DEPTH;
    localparam int OUT_REG    = ifp.OUT_REG;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_in_range;
    logic                  rd_in_range;

    always_comb begin
        wr_in_range = (int'(ifp.addra) < MEM_DEPTH);
        rd_in_range = (int'(ifp.addrb) < MEM_DEPTH);
    end

    // The array is sampled before this edge's write lands, which gives read-first behaviour.
    always_comb begin
        rd_d = rd_q;
        if (ifp.renb) begin
            if (rd_in_range) begin
                rd_d = mem[ifp.addrb];
            end else begin
                rd_d = '0;
            end
        end
    end

    // Memory contents are deliberately left alone by reset; only the read register clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
            if (wr_in_range) begin
                for (int i = 0; i < STRB_WIDTH; i++) begin
                    if (ifp.wena[i]) begin
                        mem[ifp.addra][8*i +: 8] <= ifp.dina[8*i +: 8];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_d;
            logic [DATA_WIDTH-1:0] out_q;

            always_comb begin
                out_d = rd_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign ifp.doutb = out_q;
        end else begin : g_no_out_reg
            assign ifp.doutb = rd_q;
        end
    endgenerate
endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed table plus hand sequences for simple_dual_port_ram: one instance at defaults,
// one with OUT_REG=1 and a non-power-of-two depth for latency and out-of-range reads.
module tb_simple_dual_port_ram;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sdpram_if if0 ();
    sdpram_if #(.MEM_DEPTH(1000), .OUT_REG(1)) if1 ();

    simple_dual_port_ram dut0 (.clk(clk), .rst(rst), .ifp(if0));
    simple_dual_port_ram dut1 (.clk(clk), .rst(rst), .ifp(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wena;
        logic [9:0]  addra;
        logic [31:0] dina;
        logic        renb;
        logic [9:0]  addrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    logic [31:0] mdl [16];
    logic [3:0]  mval [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        if0.wena  = v.wena;
        if0.addra = v.addra;
        if0.dina  = v.dina;
        if0.renb  = v.renb;
        if0.addrb = v.addrb;
        stepClock();
    endtask

    task automatic drive1(input logic [3:0] we, input logic [9:0] wa, input logic [31:0] wd,
                          input logic re, input logic [9:0] ra);
        if1.wena  = we;
        if1.addra = wa;
        if1.dina  = wd;
        if1.renb  = re;
        if1.addrb = ra;
        stepClock();
    endtask

    task automatic idle0();
        if0.wena = 4'h0;
        if0.renb = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_r;
        logic        exp_ok;
        int          ra;
        int          wa;
        logic [3:0]  we;
        logic [31:0] wd;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        if0.wena = '0; if0.addra = '0; if0.dina = '0; if0.renb = 1'b0; if0.addrb = '0;
        if1.wena = '0; if1.addra = '0; if1.dina = '0; if1.renb = 1'b0; if1.addrb = '0;

        vecs[0]  = '{4'hF, 10'h3FF, 32'hDEADBEEF, 1'b0, 10'h000, 32'h00000000};
        vecs[1]  = '{4'h0, 10'h000, 32'h00000000, 1'b1, 10'h3FF, 32'hDEADBEEF};
        vecs[2]  = '{4'hF, 10'h005, 32'h11223344, 1'b0, 10'h000, 32'hDEADBEEF};
        vecs[3]  = '{4'h5, 10'h005, 32'hAABBCCDD, 1'b0, 10'h000, 32'hDEADBEEF};
        vecs[4]  = '{4'h0, 10'h000, 32'h00000000, 1'b1, 10'h005, 32'h11BB33DD};
        vecs[5]  = '{4'hF, 10'h007, 32'h00000001, 1'b0, 10'h000, 32'h11BB33DD};
        vecs[6]  = '{4'hF, 10'h007, 32'h00000002, 1'b1, 10'h007, 32'h00000001};
        vecs[7]  = '{4'h0, 10'h000, 32'h00000000, 1'b1, 10'h007, 32'h00000002};
        vecs[8]  = '{4'h0, 10'h000, 32'h00000000, 1'b1, 10'h005, 32'h11BB33DD};
        vecs[9]  = '{4'h0, 10'h000, 32'h00000000, 1'b0, 10'h007, 32'h11BB33DD};
        vecs[10] = '{4'h0, 10'h005, 32'hFFFFFFFF, 1'b1, 10'h005, 32'h11BB33DD};
        vecs[11] = '{4'h8, 10'h005, 32'h99000000, 1'b1, 10'h3FF, 32'hDEADBEEF};
        vecs[12] = '{4'h0, 10'h000, 32'h00000000, 1'b1, 10'h005, 32'h99BB33DD};

        repeat (3) stepClock();
        checkOutput("reset_dout0", if0.doutb, 32'h0);
        checkOutput("reset_dout1", if1.doutb, 32'h0);
        rst = 1'b1;
        stepClock();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), if0.doutb, vecs[i].exp);
        end
        idle0();

        // Two-cycle read path on the OUT_REG=1 instance
        drive1(4'hF, 10'd10, 32'h12345678, 1'b0, 10'd0);
        checkOutput("lat_idle", if1.doutb, 32'h0);
        drive1(4'h0, 10'd0, 32'h0, 1'b1, 10'd10);
        checkOutput("lat_cycle1", if1.doutb, 32'h0);
        drive1(4'h0, 10'd0, 32'h0, 1'b0, 10'd20);
        checkOutput("lat_cycle2", if1.doutb, 32'h12345678);
        drive1(4'h0, 10'd0, 32'h0, 1'b0, 10'd30);
        checkOutput("lat_hold", if1.doutb, 32'h12345678);

        // Asynchronous reset mid-run, with a write attempted while held
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_dout0", if0.doutb, 32'h0);
        checkOutput("async_rst_dout1", if1.doutb, 32'h0);
        if0.wena = 4'hF; if0.addra = 10'h005; if0.dina = 32'h0; if0.renb = 1'b1; if0.addrb = 10'h3FF;
        stepClock();
        checkOutput("rst_read_blocked", if0.doutb, 32'h0);
        idle0();
        #2;
        rst = 1'b1;
        if0.renb = 1'b1; if0.addrb = 10'h005;
        stepClock();
        checkOutput("mem_kept_5", if0.doutb, 32'h99BB33DD);
        if0.addrb = 10'h3FF;
        stepClock();
        checkOutput("mem_kept_3ff", if0.doutb, 32'hDEADBEEF);
        idle0();

        // Out-of-range write ignored and read returns zero on the depth-1000 instance
        drive1(4'hF, 10'd1000, 32'hCAFEF00D, 1'b1, 10'd10);
        checkOutput("oor_pre", if1.doutb, 32'h0);
        drive1(4'h0, 10'd0, 32'h0, 1'b1, 10'd1000);
        checkOutput("oor_prev_word", if1.doutb, 32'h12345678);
        drive1(4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        checkOutput("oor_read_zero", if1.doutb, 32'h0);

        // Random regression against a byte-masked read-first model
        for (int k = 0; k < 16; k++) begin
            mdl[k]  = '0;
            mval[k] = '0;
        end
        for (int c = 0; c < 100; c++) begin
            ra = int'($urandom_range(0, 15));
            wa = int'($urandom_range(0, 15));
            we = 4'($urandom_range(0, 15));
            wd = $urandom;
            exp_ok = (mval[ra] == 4'hF);
            exp_r  = mdl[ra];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mdl[wa][8*b +: 8] = wd[8*b +: 8];
                    mval[wa][b] = 1'b1;
                end
            end
            if0.wena  = we;
            if0.addra = 10'h100 | 10'(wa);
            if0.dina  = wd;
            if0.renb  = 1'b1;
            if0.addrb = 10'h100 | 10'(ra);
            stepClock();
            if (exp_ok) begin
                checkOutput($sformatf("rand%0d", c), if0.doutb, exp_r);
            end
        end
        idle0();
        stepClock();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
